// File: rtl/audio_pwm_multi.sv
// -----------------------------------------------------------------------------
// audio_pwm_multi
//   Multi-channel 1-bit audio DAC. Each channel turns a signed 16-bit sample
//   into a WIDTH-bit unsigned level and drives it out as either PWM or
//   first-order sigma-delta. Samples pass through a one-deep pending buffer
//   and become active only at period boundaries, so the level on the wire
//   never changes mid-period.
//
// Parameters
//   WIDTH        DAC resolution in bits (4..16); period is 2**WIDTH clocks
//   CHANNELS     number of independent outputs (1..8)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   sample_in    CHANNELS signed 16-bit samples, channel k at [16k+15:16k]
//   sample_valid sample_in holds a sample to be taken
//   sample_ready pending buffer is empty, a valid sample is taken this cycle
//   mode         0 = PWM, 1 = sigma-delta (latched at period boundary)
//   mute         captured with the sample; forces the midpoint level
//   vol          captured with the sample; arithmetic right shift 0..3
//   out          registered 1-bit DAC outputs, one per channel
//   period_start one-cycle pulse while the period counter is 0
// -----------------------------------------------------------------------------
module audio_pwm_multi #(
   parameter int WIDTH    = 9,
   parameter int CHANNELS = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [CHANNELS*16-1:0] sample_in,
   input  logic                   sample_valid,
   output logic                   sample_ready,
   input  logic                   mode,
   input  logic                   mute,
   input  logic [1:0]             vol,
   output logic [CHANNELS-1:0]    out,
   output logic                   period_start
);

   localparam logic [WIDTH-1:0] LEVEL_MID = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] CNT_LAST  = '1;

   // Signed sample -> unsigned offset-binary level, attenuated then truncated
   // to the DAC resolution. Adding 0x8000 modulo 2**16 is an MSB flip.
   function automatic logic [WIDTH-1:0] level_of(input logic signed [15:0] s,
                                                 input logic [1:0]         v,
                                                 input logic               m);
      logic signed [15:0] a;
      logic [15:0]        u;
      a = s >>> v;
      u = {~a[15], a[14:0]};
      return m ? LEVEL_MID : WIDTH'(u >> (16 - WIDTH));
   endfunction

   logic [WIDTH-1:0]                 cnt_q, cnt_d;
   logic                             pend_full_q, pend_full_d;
   logic [CHANNELS*16-1:0]           pend_sample_q, pend_sample_d;
   logic [1:0]                       pend_vol_q, pend_vol_d;
   logic                             pend_mute_q, pend_mute_d;
   logic [CHANNELS-1:0][WIDTH-1:0]   level_q, level_d;
   logic                             mode_q, mode_d;
   logic [CHANNELS-1:0][WIDTH:0]     acc_q, acc_d;
   logic [CHANNELS-1:0]              out_q, out_d;
   logic                             period_start_q, period_start_d;

   logic                             boundary;
   logic                             accept;
   logic [WIDTH:0]                   sum;

   assign boundary     = (cnt_q == CNT_LAST);
   assign accept       = sample_valid && !pend_full_q;
   assign sample_ready = !pend_full_q;
   assign out          = out_q;
   assign period_start = period_start_q;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      cnt_d          = cnt_q + 1'b1;
      pend_full_d    = pend_full_q;
      pend_sample_d  = pend_sample_q;
      pend_vol_d     = pend_vol_q;
      pend_mute_d    = pend_mute_q;
      level_d        = level_q;
      mode_d         = mode_q;
      acc_d          = acc_q;
      out_d          = out_q;
      sum            = '0;

      // Capture and transfer are mutually exclusive: capture needs an empty
      // buffer, transfer needs a full one.
      if (accept) begin
         pend_full_d   = 1'b1;
         pend_sample_d = sample_in;
         pend_vol_d    = vol;
         pend_mute_d   = mute;
      end

      for (int k = 0; k < CHANNELS; k++) begin
         sum = {1'b0, acc_q[k][WIDTH-1:0]} + {1'b0, level_q[k]};
         if (mode_q) begin
            acc_d[k] = sum;
            out_d[k] = sum[WIDTH];
         end else begin
            out_d[k] = (cnt_q < level_q[k]);
         end
      end

      if (boundary) begin
         mode_d = mode;
         if (pend_full_q) begin
            pend_full_d = 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
               level_d[k] = level_of(pend_sample_q[16*k +: 16], pend_vol_q, pend_mute_q);
            end
         end
         // A mode change starts the modulators from a clean state.
         if (mode != mode_q) begin
            acc_d = '0;
         end
      end

      period_start_d = (cnt_d == '0);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q          <= '0;
         pend_full_q    <= 1'b0;
         pend_sample_q  <= '0;
         pend_vol_q     <= '0;
         pend_mute_q    <= 1'b0;
         level_q        <= {CHANNELS{LEVEL_MID}};
         mode_q         <= 1'b0;
         acc_q          <= '0;
         out_q          <= '0;
         period_start_q <= 1'b0;
      end else begin
         cnt_q          <= cnt_d;
         pend_full_q    <= pend_full_d;
         pend_sample_q  <= pend_sample_d;
         pend_vol_q     <= pend_vol_d;
         pend_mute_q    <= pend_mute_d;
         level_q        <= level_d;
         mode_q         <= mode_d;
         acc_q          <= acc_d;
         out_q          <= out_d;
         period_start_q <= period_start_d;
      end
   end

endmodule

// File: tb/tb_audio_pwm_multi.sv
// -----------------------------------------------------------------------------
// tb_audio_pwm_multi
//   Directed bench for audio_pwm_multi at WIDTH=9, CHANNELS=2 (512-cycle
//   period). Outputs are sampled on the falling clock edge; inputs are driven
//   there too. Expected counts are hand-derived from the level formula.
// -----------------------------------------------------------------------------
module tb_audio_pwm_multi;

   localparam int WIDTH    = 9;
   localparam int CHANNELS = 2;
   localparam int PERIOD   = 512;
   localparam int LIMIT    = 1100;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic [CHANNELS*16-1:0] sample_in;
   logic                   sample_valid;
   logic                   sample_ready;
   logic                   mode;
   logic                   mute;
   logic [1:0]             vol;
   logic [CHANNELS-1:0]    out;
   logic                   period_start;

   int errors = 0;
   int checks = 0;

   audio_pwm_multi #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .mode         (mode),
      .mute         (mute),
      .vol          (vol),
      .out          (out),
      .period_start (period_start)
   );

   always #5 clk = ~clk;

   // Count high samples per channel and period_start pulses over one period.
   task automatic measure(output int h0, output int h1, output int ps);
      h0 = 0; h1 = 0; ps = 0;
      for (int i = 0; i < PERIOD; i++) begin
         @(negedge clk);
         h0 += int'(out[0]);
         h1 += int'(out[1]);
         ps += int'(period_start);
      end
   endtask

   task automatic wait_ps(output int n, output bit ok);
      ok = 1'b0; n = 0;
      for (int i = 0; i < LIMIT && !ok; i++) begin
         @(negedge clk);
         n++;
         if (period_start) ok = 1'b1;
      end
   endtask

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < LIMIT && !ok; i++) begin
         @(negedge clk);
         if (sample_ready) ok = 1'b1;
      end
   endtask

   // Offer one sample for a single cycle; ready must be high when offered.
   task automatic offer(input logic [31:0] s, input logic [1:0] v, input logic m);
      sample_in = s; vol = v; mute = m; sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   task automatic test_reset();
      int h0, h1, ps, n;
      bit ok;
      rst_n = 1'b0; sample_in = '0; sample_valid = 1'b0;
      mode = 1'b0; mute = 1'b0; vol = 2'd0;
      #1;
      checks++;
      if (sample_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", sample_ready); end
      checks++;
      if (out !== 2'b00) begin errors++; $display("FAIL reset_out got=%b exp=00", out); end
      checks++;
      if (period_start !== 1'b0) begin errors++; $display("FAIL reset_ps got=%b exp=0", period_start); end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait_ps(n, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL idle_ps_timeout got=none exp=pulse"); end
      measure(h0, h1, ps);
      checks++;
      if (h0 !== 256) begin errors++; $display("FAIL idle_ch0 got=%0d exp=256", h0); end
      checks++;
      if (h1 !== 256) begin errors++; $display("FAIL idle_ch1 got=%0d exp=256", h1); end
      checks++;
      if (ps !== 1) begin errors++; $display("FAIL idle_ps_count got=%0d exp=1", ps); end
      checks++;
      if (sample_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got=%b exp=1", sample_ready); end
   endtask

   task automatic test_full_scale();
      int h0, h1, ps;
      bit ok;
      offer({16'h8000, 16'h7FFF}, 2'd0, 1'b0);
      checks++;
      if (sample_ready !== 1'b0) begin errors++; $display("FAIL fs_ready_low got=%b exp=0", sample_ready); end
      wait_ready(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL fs_ready_timeout got=0 exp=1"); end
      measure(h0, h1, ps);
      checks++;
      if (h0 !== 511) begin errors++; $display("FAIL fs_ch0 got=%0d exp=511", h0); end
      checks++;
      if (h1 !== 0) begin errors++; $display("FAIL fs_ch1 got=%0d exp=0", h1); end
   endtask

   task automatic test_back_to_back();
      int h0, h1, ps;
      bit ok;
      // A: ch0 0x7FFF>>>2 -> 319, ch1 0x8000>>>2 -> 0xE000 -> 192. B: muted.
      sample_in = {16'h8000, 16'h7FFF}; vol = 2'd2; mute = 1'b0; sample_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (sample_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_after_a got=%b exp=0", sample_ready); end
      sample_in = {16'h1234, 16'h4321}; vol = 2'd0; mute = 1'b1;
      wait_ready(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL b2b_ready_timeout got=0 exp=1"); end
      checks++;
      if (period_start !== 1'b1) begin errors++; $display("FAIL b2b_ready_at_boundary got=%b exp=1", period_start); end
      @(negedge clk);
      sample_valid = 1'b0;
      checks++;
      if (sample_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_after_b got=%b exp=0", sample_ready); end
      // One sample of this period already seen; 511 more plus the next cnt==0.
      h0 = int'(out[0]); h1 = int'(out[1]);
      for (int i = 0; i < PERIOD - 1; i++) begin
         @(negedge clk);
         h0 += int'(out[0]);
         h1 += int'(out[1]);
      end
      checks++;
      if (h0 !== 319) begin errors++; $display("FAIL vol2_ch0 got=%0d exp=319", h0); end
      checks++;
      if (h1 !== 192) begin errors++; $display("FAIL vol2_ch1 got=%0d exp=192", h1); end
      checks++;
      if (sample_ready !== 1'b1 || period_start !== 1'b1) begin
         errors++; $display("FAIL b2b_second_transfer got=%b%b exp=11", sample_ready, period_start);
      end
      measure(h0, h1, ps);
      checks++;
      if (h0 !== 256) begin errors++; $display("FAIL mute_ch0 got=%0d exp=256", h0); end
      checks++;
      if (h1 !== 256) begin errors++; $display("FAIL mute_ch1 got=%0d exp=256", h1); end
   endtask

   task automatic test_sigma_delta();
      int h0, h1;
      bit ok;
      logic [7:0] pat;
      // 0xC000 -> u = 0x4000 -> level 128: carry every 4th cycle.
      mode = 1'b1;
      offer({16'hC000, 16'hC000}, 2'd0, 1'b0);
      wait_ready(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL sd_ready_timeout got=0 exp=1"); end
      h0 = 0; h1 = 0; pat = '0;
      for (int i = 0; i < PERIOD; i++) begin
         @(negedge clk);
         h0 += int'(out[0]);
         h1 += int'(out[1]);
         if (i < 8) pat[i] = out[0];
      end
      checks++;
      if (pat !== 8'b1000_1000) begin errors++; $display("FAIL sd_pattern got=%b exp=10001000", pat); end
      checks++;
      if (h0 !== 128) begin errors++; $display("FAIL sd_ch0 got=%0d exp=128", h0); end
      checks++;
      if (h1 !== 128) begin errors++; $display("FAIL sd_ch1 got=%0d exp=128", h1); end
      // Back to PWM with full scale: first cycles must be solid ones.
      mode = 1'b0;
      offer({16'h7FFF, 16'h7FFF}, 2'd0, 1'b0);
      wait_ready(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL pwm_ready_timeout got=0 exp=1"); end
      h0 = 0; h1 = 0; pat = '0;
      for (int i = 0; i < PERIOD; i++) begin
         @(negedge clk);
         h0 += int'(out[0]);
         h1 += int'(out[1]);
         if (i < 8) pat[i] = out[1];
      end
      checks++;
      if (pat !== 8'hFF) begin errors++; $display("FAIL pwm_pattern got=%b exp=11111111", pat); end
      checks++;
      if (h0 !== 511 || h1 !== 511) begin errors++; $display("FAIL pwm_return got=%0d/%0d exp=511/511", h0, h1); end
   endtask

   task automatic test_mid_reset();
      int h0, h1, ps, n;
      bit ok;
      // At cnt==0 now; queue a level-0 sample then run to cnt==300.
      sample_in = {16'h8000, 16'h8000}; vol = 2'd0; mute = 1'b0; sample_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         sample_valid = 1'b0;
      end
      checks++;
      if (sample_ready !== 1'b0) begin errors++; $display("FAIL mr_pending got=%b exp=0", sample_ready); end
      checks++;
      if (out !== 2'b11) begin errors++; $display("FAIL mr_pre_out got=%b exp=11", out); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out !== 2'b00) begin errors++; $display("FAIL mr_async_out got=%b exp=00", out); end
      checks++;
      if (sample_ready !== 1'b1) begin errors++; $display("FAIL mr_async_ready got=%b exp=1", sample_ready); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (out !== 2'b11) begin errors++; $display("FAIL mr_resume_out got=%b exp=11", out); end
      wait_ps(n, ok);
      checks++;
      if (!ok || n !== 511) begin errors++; $display("FAIL mr_restart_phase got=%0d exp=511", n); end
      measure(h0, h1, ps);
      checks++;
      if (h0 !== 256 || h1 !== 256) begin errors++; $display("FAIL mr_midpoint got=%0d/%0d exp=256/256", h0, h1); end
      checks++;
      if (ps !== 1) begin errors++; $display("FAIL mr_ps_count got=%0d exp=1", ps); end
   endtask

   initial begin
      test_reset();
      test_full_scale();
      test_back_to_back();
      test_sigma_delta();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/audio_pwm_multi.md
AUDIO_PWM_MULTI -- requirements
Module: audio_pwm_multi

Interface
REQ-001 SHALL have parameter WIDTH, default 9, meaning DAC resolution in bits (legal 4..16).
REQ-002 SHALL have parameter CHANNELS, default 2, meaning the number of independent audio outputs (legal 1..8).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port sample_in, input, CHANNELS*16 bits: signed 16-bit samples; channel k is at [16k+15:16k].
REQ-006 SHALL have port sample_valid, input, 1 bit: sample_in is valid.
REQ-007 SHALL have port sample_ready, output, 1 bit: the pending buffer is empty.
REQ-008 SHALL have port mode, input, 1 bit: 0 = PWM, 1 = first-order sigma-delta.
REQ-009 SHALL have port mute, input, 1 bit: force every channel to the midpoint level.
REQ-010 SHALL have port vol, input, 2 bits: attenuation as an arithmetic right shift of 0..3.
REQ-011 SHALL have port out, output, CHANNELS bits: registered 1-bit DAC outputs.
REQ-012 SHALL have port period_start, output, 1 bit: one-cycle pulse when cnt==0.

Function
REQ-013 SHALL run a free-running WIDTH-bit counter cnt that wraps from 2^WIDTH-1 to 0, giving a period of 2^WIDTH clk cycles.
REQ-014 SHALL drive sample_ready = !pend_full, decoded combinationally from the state register.
REQ-015 SHALL capture sample_in, vol and mute into the pending buffer, and set pend_full, on any cycle with sample_valid && sample_ready.
REQ-016 SHALL perform the boundary update only when cnt==2^WIDTH-1 (last cycle of a period), as follows.
- Pending buffer full: copy it to the active levels and clear pend_full.
- Pending buffer empty: hold the active levels unchanged.
REQ-017 SHALL latch mode at the boundary; if the latched mode changes, all sigma-delta accumulators SHALL clear to 0 in the same update.
REQ-018 SHALL accept a new sample into the now-empty pending buffer no earlier than the cycle after a boundary transfer, because sample_ready was low during the transfer cycle.
REQ-019 SHALL compute each level per channel as follows.
- a = s >>> vol (16-bit signed arithmetic shift).
- u = a + 16'h8000 (modulo 2^16, i.e. MSB inverted).
- level = u[15:16-WIDTH].
- If mute=1, level = 2^(WIDTH-1).
REQ-020 SHALL, in PWM mode, register out[k] <= (cnt < level_k), so out follows cnt by one cycle; level 0 gives constant 0 and level 2^WIDTH-1 gives 2^WIDTH-1 high cycles per period.
REQ-021 SHALL, in sigma-delta mode, use a (WIDTH+1)-bit accumulator per channel with acc_k <= acc_k[WIDTH-1:0] + level_k and out[k] <= acc_k carry bit (bit WIDTH) of that sum.
REQ-022 SHALL assert period_start for exactly one cycle on each cycle with cnt==0.
REQ-023 SHALL make each level take effect at the first cnt==0 after its transfer, giving a worst-case sample-to-output latency of 2*2^WIDTH+1 cycles.
REQ-024 SHALL never drop or duplicate an accepted sample; samples offered while sample_ready=0 SHALL NOT be captured.

Reset
REQ-025 SHALL, while rst_n=0 (taking effect asynchronously), set the following state.
- cnt=0 and out=0.
- period_start=0.
- pend_full=0, so sample_ready=1.
- Accumulators=0 and latched mode=0.
- Active levels = 2^(WIDTH-1).
REQ-026 SHALL restart counting from cnt=0 on the first rising clk after rst_n deasserts, and a reset mid-period SHALL discard pending and active samples.

Verification (WIDTH=9, CHANNELS=2)
REQ-027 Reset and idle: release rst_n with no samples -> sample_ready=1, out high exactly 256 of every 512 cycles, and period_start every 512 cycles.
REQ-028 Full scale: sample 0x7FFF/0x8000 (ch0/ch1), vol=0 -> after the boundary, ch0 is high 511 of 512 cycles and ch1 is constant 0.
REQ-029 Backpressure: two valid samples back-to-back -> the first is accepted, sample_ready=0 until the boundary cycle, and the second is accepted on the following cycle with no loss.
REQ-030 Volume and mute: 0x7FFF with vol=2 -> level 319 (319 high cycles per period); mute=1 -> 256 high cycles.
REQ-031 Sigma-delta: mode=1, level 128 -> out=1 exactly once every 4 cycles, 128 ones per 512 cycles; switching mode clears the accumulators at the boundary.
REQ-032 Mid-period reset: assert rst_n=0 at cnt=300 with pend_full=1 -> out=0 and sample_ready=1 immediately without a clock; after release the midpoint output resumes from cnt=0.
